// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, buffers {pc, instr} pairs, handles redirect/halt/fault.
// Optional perf counters (perf_fetched, perf_stall) are built when IMEM_FETCH_PERF_EN is defined.
module imem_fetch_ctrl #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc,
    output logic                  fault,
    output logic [31:0]           fault_pc
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [31:0]      pc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [31:0]      fifo_pc_r    [FIFO_DEPTH];
    logic [31:0]      fifo_instr_r [FIFO_DEPTH];
    logic             fault_r;
    logic [31:0]      fault_pc_r;

    logic             redir_live_s;
    logic             redir_ok_s;
    logic             redir_bad_s;
    logic             out_valid_s;
    logic             pop_s;
    logic             push_s;
    logic             full_s;

    assign redir_live_s = redirect_valid && (state_r != ST_FAULT);
    assign redir_ok_s   = redir_live_s && (redirect_pc[1:0] == 2'b00);
    assign redir_bad_s  = redir_live_s && (redirect_pc[1:0] != 2'b00);
    assign out_valid_s  = (cnt_r != {CNT_W{1'b0}}) && (state_r != ST_FAULT);
    assign pop_s        = out_valid_s && out_ready;
    assign full_s       = (cnt_r == CNT_W'(FIFO_DEPTH));
    // Any redirect (good or bad) suppresses the push; a full FIFO may still push if the head retires.
    assign push_s       = (state_r == ST_FETCH) && !halt && !redirect_valid && (!full_s || pop_s);

    assign imem_addr  = pc_r[ADDR_WIDTH+1:2];
    assign out_valid  = out_valid_s;
    assign out_pc     = out_valid_s ? fifo_pc_r[rd_ptr_r]    : 32'h0000_0000;
    assign out_instr  = out_valid_s ? fifo_instr_r[rd_ptr_r] : 32'h0000_0000;
    assign fault      = fault_r;
    assign fault_pc   = fault_pc_r;

    // Next-state selection; a misaligned redirect dominates, an aligned one with halt parks in HALTED.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = ST_FETCH;
            ST_FETCH:  if (halt) state_nxt_s = ST_HALTED; else state_nxt_s = ST_FETCH;
            ST_HALTED: if (!halt) state_nxt_s = ST_FETCH; else state_nxt_s = ST_HALTED;
            ST_FAULT:  state_nxt_s = ST_FAULT;
            default:   state_nxt_s = ST_FAULT;
        endcase
        if (redir_bad_s) begin
            state_nxt_s = ST_FAULT;
        end else if (redir_ok_s && halt) begin
            state_nxt_s = ST_HALTED;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, PC and sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            fault_r    <= 1'b0;
            fault_pc_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (redir_ok_s) begin
                pc_r <= redirect_pc;
            end else if (push_s) begin
                pc_r <= pc_r + 32'd4;
            end
            if (redir_bad_s) begin
                fault_r    <= 1'b1;
                fault_pc_r <= redirect_pc;
            end
        end
    end

    // FIFO occupancy and pointers; any redirect empties the buffer, even an entry retiring this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (redir_live_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            if (push_s && !pop_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]    <= 32'h0000_0000;
                fifo_instr_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= pc_r;
            fifo_instr_r[wr_ptr_r] <= imem_data;
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;

    // Saturating event counters; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_stall_r   <= 32'h0000_0000;
        end else begin
            if (push_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if ((state_r == ST_FETCH) && full_s && !pop_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: queue-based reference model, directed scenarios and random traffic.
// Build with IMEM_FETCH_PERF_EN defined to also check the perf counters.
module tb_imem_fetch_ctrl;

    localparam int          AW    = 8;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          VW    = 1 + 32 + 32 + AW + 1 + 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          halt = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          fault;
    logic [31:0]   fault_pc;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: spec-level view as a queue of buffered PCs plus a few mode flags.
    logic [31:0]  m_q[$];
    logic [31:0]  m_pc;
    logic         m_started, m_halted, m_faulted;
    logic [31:0]  m_fpc;
    int unsigned  m_fetched, m_stall;

    imem_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .fault(fault), .fault_pc(fault_pc)
`ifdef IMEM_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    assign imem_data = 32'h1000_0000 + 32'(imem_addr);

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + 32'(pc[AW+1:2]);
    endfunction

    function automatic logic exp_valid();
        return !m_faulted && (m_q.size() > 0);
    endfunction

    function automatic logic [31:0] exp_pc();
        return exp_valid() ? m_q[0] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return exp_valid() ? word_of(m_q[0]) : 32'h0;
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {out_valid, out_pc, out_instr, imem_addr, fault, fault_pc};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_valid(), exp_pc(), exp_instr(), m_pc[AW+1:2], m_faulted, m_fpc};
    endfunction

    function automatic string obs_s();
        return $sformatf("v=%b pc=%h ins=%h a=%0d f=%b fpc=%h", out_valid, out_pc, out_instr, imem_addr, fault, fault_pc);
    endfunction

    function automatic string exp_s();
        return $sformatf("v=%b pc=%h ins=%h a=%0d f=%b fpc=%h", exp_valid(), exp_pc(), exp_instr(), m_pc[AW+1:2], m_faulted, m_fpc);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc = RPC; m_started = 1'b0; m_halted = 1'b0; m_faulted = 1'b0;
        m_fpc = 32'h0; m_fetched = 0; m_stall = 0;
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic hlt, input logic rdy);
        logic pop;
        logic fetching;
        pop      = exp_valid() && rdy;
        fetching = !m_faulted && m_started && !m_halted;
        if (fetching && (m_q.size() == DEPTH) && !pop) m_stall++;
        if (m_faulted) begin
            m_faulted = 1'b1;
        end else if (rv && (rpc[1:0] != 2'b00)) begin
            m_faulted = 1'b1; m_fpc = rpc; m_q.delete();
        end else if (rv) begin
            m_q.delete(); m_pc = rpc; m_started = 1'b1; m_halted = hlt;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (!m_started) m_started = 1'b1;
            else if (m_halted) m_halted = hlt;
            else if (hlt) m_halted = 1'b1;
            else if (m_q.size() < DEPTH) begin
                m_q.push_back(m_pc); m_pc = m_pc + 32'd4; m_fetched++;
            end
        end
    endtask

    // One clock: inputs applied at the falling edge, model advanced at the rising edge.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic hlt, input logic rdy);
        redirect_valid = rv; redirect_pc = rpc; halt = hlt; out_ready = rdy;
        @(posedge clk);
        model_step(rv, rpc, hlt, rdy);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    // Occupancy must never exceed the buffer depth.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (int'(dut.cnt_r) > DEPTH) begin
                errors++; $display("FAIL count_bound: got %0d, limit %0d", dut.cnt_r, DEPTH);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        model_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset: got %s, want %s", obs_s(), exp_s()); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL stream[%0d]: got %s, want %s", i, obs_s(), exp_s()); end
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'(4 * (i - 1)) || out_instr !== 32'h1000_0000 + 32'(i - 1)) begin
                    errors++; $display("FAIL stream_seq[%0d]: got v=%b pc=%h ins=%h, want pc=%h", i, out_valid, out_pc, out_instr, 32'(4 * (i - 1)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] last;
        held = exp_pc();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || out_pc !== held) begin
                errors++; $display("FAIL bp_hold[%0d]: got %s, want %s", i, obs_s(), exp_s());
            end
        end
        checks++;
        if (int'(dut.cnt_r) != DEPTH) begin errors++; $display("FAIL bp_full: got %0d, want %0d", dut.cnt_r, DEPTH); end
        last = held - 32'd4;
        for (int i = 0; i < 5; i++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_pc !== last + 32'd4) begin errors++; $display("FAIL bp_order[%0d]: got %h, want %h", i, out_pc, last + 32'd4); end
                last = out_pc;
            end
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL bp_release[%0d]: got %s, want %s", i, obs_s(), exp_s()); end
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0020, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin errors++; $display("FAIL redir_flush: got %s, want %s", obs_s(), exp_s()); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h1000_0008) begin
            errors++; $display("FAIL redir_target: got v=%b pc=%h ins=%h, want pc=00000020 ins=10000008", out_valid, out_pc, out_instr);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL redir_after[%0d]: got %s, want %s", i, obs_s(), exp_s()); end
        end
    endtask

    task automatic test_halt();
        logic [31:0] resume_pc;
        int n;
        resume_pc = m_pc;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL halt[%0d]: got %s, want %s", i, obs_s(), exp_s()); end
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_drained: got v=%b, want 0", out_valid); end
        n = 0;
        do begin cycle(1'b0, 32'h0, 1'b0, 1'b1); n++; end while (out_valid !== 1'b1 && n < 6);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== resume_pc) begin
            errors++; $display("FAIL halt_resume: got v=%b pc=%h, want pc=%h", out_valid, out_pc, resume_pc);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0040, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL halt_redir: got %s, want %s", obs_s(), exp_s()); end
        n = 0;
        do begin cycle(1'b0, 32'h0, 1'b0, 1'b1); n++; end while (out_valid !== 1'b1 && n < 6);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
            errors++; $display("FAIL halt_redir_resume: got v=%b pc=%h, want pc=00000040", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] p0;
        cycle(1'b1, 32'h0000_03FC, 1'b0, 1'b1);
        checks++;
        if (imem_addr !== 8'd255) begin errors++; $display("FAIL wrap_addr0: got %0d, want 255", imem_addr); end
`ifdef IMEM_FETCH_PERF_EN
        p0 = perf_fetched;
`else
        p0 = 32'h0;
`endif
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (imem_addr !== 8'd0 || out_pc !== 32'h3FC || out_instr !== 32'h1000_00FF) begin
            errors++; $display("FAIL wrap_first: got a=%0d pc=%h ins=%h, want a=0 pc=000003fc ins=100000ff", imem_addr, out_pc, out_instr);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (out_pc !== 32'h400 || out_instr !== 32'h1000_0000 || fault !== 1'b0) begin
            errors++; $display("FAIL wrap_second: got pc=%h ins=%h f=%b, want pc=00000400 ins=10000000 f=0", out_pc, out_instr, fault);
        end
`ifdef IMEM_FETCH_PERF_EN
        checks++;
        if (perf_fetched - p0 !== 32'd2) begin errors++; $display("FAIL wrap_perf: got delta %0d, want 2", perf_fetched - p0); end
`else
        p0 = p0 + 32'd0;
`endif
    endtask

    task automatic test_random();
        logic hlt_l;
        logic rv;
        hlt_l = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) hlt_l = ~hlt_l;
            rv = ($urandom_range(0, 11) == 0);
            cycle(rv, 32'($urandom_range(0, 511)) << 2, hlt_l, ($urandom_range(0, 3) != 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %s, want %s", i, obs_s(), exp_s()); end
`ifdef IMEM_FETCH_PERF_EN
            checks++;
            if (perf_fetched !== 32'(m_fetched) || perf_stall !== 32'(m_stall)) begin
                errors++; $display("FAIL random_perf[%0d]: got f=%0d s=%0d, want f=%0d s=%0d", i, perf_fetched, perf_stall, m_fetched, m_stall);
            end
`endif
        end
    endtask

    task automatic test_fault();
        int n;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0022, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (fault !== 1'b1 || fault_pc !== 32'h22 || out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL fault_sticky[%0d]: got %s, want %s", i, obs_s(), exp_s());
            end
            cycle(($urandom_range(0, 2) == 0), 32'h0000_0080, 1'b0, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL fault_reset: got %s, want %s", obs_s(), exp_s()); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin cycle(1'b0, 32'h0, 1'b0, 1'b1); n++; end while (out_valid !== 1'b1 && n < 6);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== word_of(RPC) || fault !== 1'b0) begin
            errors++; $display("FAIL fault_restart: got v=%b pc=%h ins=%h f=%b, want pc=%h", out_valid, out_pc, out_instr, fault, RPC);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_random();
        test_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction fetch sequencer between the PC and the combinational instruction memory (word-addressed, 2^ADDR_WIDTH x 32).
- Owns the fetch PC and drives the word address each cycle.
- Captures {pc, instr} pairs into a small in-order FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush + refetch), halt, and misaligned-target faults.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; imem holds 2^ADDR_WIDTH words.
- RESET_PC, 32'h0000_0000, first PC fetched after reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_WIDTH  word address to instruction memory; equals pc[ADDR_WIDTH+1:2].
- imem_data  in  32  combinational instruction for imem_addr, same cycle.
- redirect_valid  in  1  one-cycle pulse: change fetch PC.
- redirect_pc  in  32  target byte address, sampled when redirect_valid=1.
- halt  in  1  level: stop issuing new fetches.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head when out_valid && out_ready.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  32  byte PC of out_instr.
- fault  out  1  sticky misaligned-redirect flag.
- fault_pc  out  32  offending redirect_pc.

Behaviour:
- Reset (async assert, sync deassert use):
  - pc=RESET_PC; FIFO empty; state=IDLE.
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
  - imem_addr=RESET_PC[ADDR_WIDTH+1:2].
- Reset asserted mid-operation discards all FIFO contents and any pending redirect immediately.
- States: IDLE, FETCH, HALTED, FAULT.
  - IDLE -> FETCH on the first clock after reset deassert. No push occurs in IDLE.
  - FETCH -> HALTED when halt=1. No push occurs that cycle.
  - HALTED -> FETCH when halt=0. The PC is unchanged.
  - Any state except FAULT -> FAULT on redirect_valid with redirect_pc[1:0]!=0. This sets fault=1 and fault_pc=redirect_pc, and flushes the FIFO.
  - FAULT is left only by reset. In FAULT, out_valid=0 and nothing is pushed.
- Fetch, in FETCH only, with no redirect that cycle:
  - push = (count<FIFO_DEPTH) || (out_valid && out_ready).
  - On push, the entry {pc, imem_data} is written and pc<=pc+4.
  - Latency: an instruction is visible on out_* the cycle after its address is driven.
- Pop: head retires on out_valid && out_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
- Redirect, aligned, legal in any non-FAULT state including HALTED:
  - Highest priority.
  - The FIFO is flushed, including an entry being popped that cycle (its handshake still counts as accepted).
  - No push that cycle; pc<=redirect_pc.
  - out_valid=0 the next cycle. The first target instruction appears 2 cycles after the redirect pulse if not halted.
- Redirect plus halt in the same cycle: the PC is updated, then the block enters HALTED.
- PC arithmetic: 32-bit, wraps modulo 2^32.
  - imem_addr truncates, so PCs >= 4*2^ADDR_WIDTH alias into imem. No fault is raised for this.
- out_instr/out_pc hold their value while out_valid && !out_ready. They are 0 when the FIFO is empty.
- count width is clog2(FIFO_DEPTH)+1. Overflow and underflow are impossible by construction; a bench assertion checks this.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall (32).
  - perf_fetched counts pushes.
  - perf_stall counts FETCH cycles with the FIFO full and no pop.
  - Both counters reset to 0 on rst_n, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

Test Plan:
- Reset release with out_ready=1, imem word n = 32'h1000_0000+n:
  - Cycle 1 after IDLE gives out_pc=0, out_instr=32'h1000_0000.
  - Consecutive cycles give pc 4, 8, 12 with the matching words.
  - One instruction per cycle, no gaps.
- Backpressure: out_ready=0 for 5 cycles after the first fetch.
  - Exactly FIFO_DEPTH=2 entries are held (pc 0, 4); out_pc stays 0.
  - On release, pcs 0, 4, 8 are delivered in order with no loss or duplication.
- Redirect to 32'h0000_0020 while 2 entries are buffered:
  - Next cycle out_valid=0.
  - The following cycle out_pc=32'h20 with instr = word 8.
  - Stale pcs never appear.
- halt=1 for 3 cycles, then 0:
  - The FIFO drains with no new pushes.
  - Fetch resumes at the next sequential pc.
  - A redirect to 32'h40 during halt makes fetch resume at 32'h40.
- Redirect to 32'h0000_0022:
  - fault=1, fault_pc=32'h22, out_valid=0 permanently.
  - Assert rst_n=0 mid-run: fault clears and fetch restarts at RESET_PC.
- PC wrap, ADDR_WIDTH=8: redirect to 32'h3FC.
  - imem_addr goes 255 then 0, with out_pc 32'h3FC then 32'h400.
  - With IMEM_FETCH_PERF_EN defined, perf_fetched increments by exactly 2 over those 2 pushes.
